// File: rtl/cpu_pkg.sv
// Shared CPU definitions: redirect codes, fetch FSM states, widths and the
// default reset vector used by the IF stage.
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // PC_src encodings driven by the ID-stage controller
  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_J   = 2'b10;
  localparam logic [1:0] PCSRC_JR  = 2'b11;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction-memory request/response bus.
//   master (fetch unit): drives imem_req/imem_addr, receives ready/rvalid/rdata
//   slave  (memory)    : the mirror image
interface ifetch_unit_if #(
  parameter int unsigned XLEN = cpu_pkg::XLEN
);

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/if_id_reg.sv
// Instruction/PC+4 register with flush, load and hold controls.
// Priority: flush (clear valid) > load > hold > bubble (clear valid).
// Used both as the IF/ID pipeline register and as the fetch hold buffer.
//   clk, reset     : clock, async active-low reset
//   flush/load/hold: control
//   instr_in, pc_plus4_in : payload to load
//   instr, pc_plus4, valid: registered contents
module if_id_reg import cpu_pkg::*; #(
  parameter int unsigned XLEN = cpu_pkg::XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            load,
  input  logic            hold,
  input  logic [XLEN-1:0] instr_in,
  input  logic [XLEN-1:0] pc_plus4_in,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc_plus4,
  output logic            valid
);

  // Payload keeps stale values on flush/bubble; only valid is cleared
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr    <= '0;
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end else if (flush) begin
      valid    <= 1'b0;
    end else if (load) begin
      instr    <= instr_in;
      pc_plus4 <= pc_plus4_in;
      valid    <= 1'b1;
    end else if (!hold) begin
      valid    <= 1'b0;
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// IF stage plus IF/ID register. Owns the PC, issues one outstanding fetch at
// a time, parks a response in a one-entry buffer while ID is stalled, and
// discards wrong-path fetches on branch/j/jr redirects (no delay slots).
//   clk, reset      : clock, async active-low reset
//   PC_src          : redirect code from the controller
//   branch_target   : EX-resolved branch target (PC_src==01)
//   jr_target       : forwarded rs value (PC_src==11)
//   id_stall        : load-use stall, IF/ID holds
//   imem            : instruction-memory bus (master side)
//   ID_instruction, ID_pc_plus4, ID_valid : IF/ID register outputs
module ifetch_unit import cpu_pkg::*; #(
  parameter int unsigned    XLEN     = cpu_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      PC_src,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] jr_target,
  input  logic            id_stall,
  ifetch_unit_if.master   imem,
  output logic [XLEN-1:0] ID_instruction,
  output logic [XLEN-1:0] ID_pc_plus4,
  output logic            ID_valid
);

  fetch_state_e    state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic [XLEN-1:0] pend_pc, pend_pc_nxt;
  logic [XLEN-1:0] pend_pc_plus4;
  logic            kill, kill_nxt;

  logic            take_br, take_jmp, redirect;
  logic [XLEN-1:0] target;

  logic            deliver_mem, deliver_buf;
  logic            buf_load, buf_flush;
  logic [XLEN-1:0] buf_instr, buf_pc_plus4;
  logic            buf_valid;
  logic [XLEN-1:0] id_instr_in, id_pc_plus4_in;

  assign pend_pc_plus4 = pend_pc + XLEN'(4);

  // Request is a decode of the registered state, forced low while in reset
  assign imem.imem_req  = reset && (state == S_REQ);
  assign imem.imem_addr = {pc[XLEN-1:2], 2'b00};

  // Redirect decode: branch always wins; j/jr only act on a live, unstalled ID
  always_comb begin
    take_br  = (PC_src == PCSRC_BR);
    take_jmp = ((PC_src == PCSRC_J) || (PC_src == PCSRC_JR)) && ID_valid && !id_stall;
    redirect = take_br || take_jmp;
    target   = jr_target;
    if (take_br) begin
      target = branch_target;
    end else if (PC_src == PCSRC_J) begin
      target = XLEN'({ID_pc_plus4[XLEN-1 -: 4], ID_instruction[25:0], 2'b00});
    end
  end

  // Fetch FSM next-state and datapath controls
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    pend_pc_nxt = pend_pc;
    kill_nxt    = kill;
    deliver_mem = 1'b0;
    deliver_buf = 1'b0;
    buf_load    = 1'b0;
    buf_flush   = 1'b0;

    case (state)
      S_REQ: begin
        // A request accepted alongside a redirect is already wrong-path
        if (imem.imem_ready) begin
          pend_pc_nxt = pc;
          kill_nxt    = redirect;
          state_nxt   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem.imem_rvalid) begin
          if (kill || redirect) begin
            kill_nxt  = 1'b0;
            state_nxt = S_REQ;
          end else if (!id_stall) begin
            deliver_mem = 1'b1;
            pc_nxt      = pend_pc_plus4;
            state_nxt   = S_REQ;
          end else begin
            buf_load  = 1'b1;
            state_nxt = S_HOLD;
          end
        end else if (redirect) begin
          kill_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect || !id_stall) begin
          buf_flush = 1'b1;
          state_nxt = S_REQ;
          if (!redirect) begin
            deliver_buf = buf_valid;
            pc_nxt      = pend_pc_plus4;
          end
        end
      end
      default: begin
        state_nxt = S_REQ;
      end
    endcase

    if (redirect) begin
      pc_nxt = {target[XLEN-1:2], 2'b00};
    end
  end

  // Fetch state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_REQ;
      pc      <= RESET_PC;
      pend_pc <= RESET_PC;
      kill    <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      pend_pc <= pend_pc_nxt;
      kill    <= kill_nxt;
    end
  end

  assign id_instr_in    = deliver_buf ? buf_instr    : imem.imem_rdata;
  assign id_pc_plus4_in = deliver_buf ? buf_pc_plus4 : pend_pc_plus4;

  // Hold buffer: captures a response that arrives while ID is stalled
  if_id_reg #(.XLEN(XLEN)) u_hold_buf (
    .clk         (clk),
    .reset       (reset),
    .flush       (buf_flush),
    .load        (buf_load),
    .hold        (1'b1),
    .instr_in    (imem.imem_rdata),
    .pc_plus4_in (pend_pc_plus4),
    .instr       (buf_instr),
    .pc_plus4    (buf_pc_plus4),
    .valid       (buf_valid)
  );

  // IF/ID register: branch flush beats the stall hold
  if_id_reg #(.XLEN(XLEN)) u_if_id (
    .clk         (clk),
    .reset       (reset),
    .flush       (take_br),
    .load        (deliver_mem || deliver_buf),
    .hold        (id_stall),
    .instr_in    (id_instr_in),
    .pc_plus4_in (id_pc_plus4_in),
    .instr       (ID_instruction),
    .pc_plus4    (ID_pc_plus4),
    .valid       (ID_valid)
  );

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios plus randomized controller and
// memory behaviour, checked against an instruction-stream model.
module tb_ifetch_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  pc_src;
  logic [31:0] branch_target, jr_target;
  logic        id_stall;
  logic        ready;
  logic [31:0] id_instruction, id_pc_plus4;
  logic        id_valid;

  ifetch_unit_if #(.XLEN(32)) bus ();

  ifetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .PC_src         (pc_src),
    .branch_target  (branch_target),
    .jr_target      (jr_target),
    .id_stall       (id_stall),
    .imem           (bus),
    .ID_instruction (id_instruction),
    .ID_pc_plus4    (id_pc_plus4),
    .ID_valid       (id_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Memory image: word at 0 is programmable, everything else is a hash
  logic [31:0] word0;
  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] w0);
    if (a == 32'h0) return w0;
    return a * 32'h9E37_79B1 + 32'h2008_0005;
  endfunction

  // Memory model: response visible 'lat' cycles after acceptance (lat==0: random 1..4)
  int          lat;
  logic        m_busy;
  int          m_cnt;
  logic [31:0] m_addr;
  assign bus.imem_ready  = ready;
  assign bus.imem_rvalid = m_busy && (m_cnt == 0);
  assign bus.imem_rdata  = mem_word(m_addr, word0);

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
      m_addr <= '0;
    end else if (m_busy) begin
      if (m_cnt == 0) m_busy <= 1'b0;
      else            m_cnt  <= m_cnt - 1;
    end else if (bus.imem_req && bus.imem_ready) begin
      m_busy <= 1'b1;
      m_addr <= bus.imem_addr;
      m_cnt  <= (lat == 0) ? int'($urandom_range(3, 0)) : lat - 1;
    end
  end

  // Reference model: where the instruction stream must continue, and ID contents
  logic [31:0] exp_q[$];
  logic [31:0] acc_q[$];
  logic        m_valid;
  logic [31:0] m_instr, m_pc4;
  logic        mon_en = 1'b0;
  int          delivered = 0;
  int          idle = 0;

  logic        s_rst, s_en, s_req, s_rdy, s_stall;
  logic [1:0]  s_src;
  logic [31:0] s_addr, s_bt, s_jt;

  initial begin : monitor
    logic        br, jmp;
    logic [31:0] tgt, p;
    forever begin
      @(negedge clk);
      #4;
      s_rst = reset;  s_en = mon_en;
      s_req = bus.imem_req; s_rdy = bus.imem_ready; s_addr = bus.imem_addr;
      s_stall = id_stall; s_src = pc_src; s_bt = branch_target; s_jt = jr_target;
      @(posedge clk);
      #1;
      if (!s_rst || !reset || !s_en) begin
        m_valid = 1'b0; m_instr = '0; m_pc4 = '0; idle = 0;
        exp_q.delete();
        exp_q.push_back(32'h0000_0000);
        continue;
      end
      if (s_req) check("addr_align", 32'(s_addr[1:0]), 32'h0);
      if (s_req && s_rdy) acc_q.push_back(s_addr);
      br  = (s_src == PCSRC_BR);
      jmp = s_src[1] && m_valid && !s_stall;
      idle++;
      if (br || jmp) begin
        if (br)                    tgt = s_bt;
        else if (s_src == PCSRC_J) tgt = {m_pc4[31:28], m_instr[25:0], 2'b00};
        else                       tgt = s_jt;
        check("redirect_bubble", 32'(id_valid), 32'h0);
        m_valid = 1'b0;
        exp_q.delete();
        exp_q.push_back(tgt & ~32'h3);
        idle = 0;
      end else if (s_stall) begin
        check("stall_hold_valid", 32'(id_valid), 32'(m_valid));
        if (m_valid) begin
          check("stall_hold_instr", id_instruction, m_instr);
          check("stall_hold_pc4", id_pc_plus4, m_pc4);
        end
      end else if (id_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL stream: unexpected delivery pc4=%08h", id_pc_plus4);
        end else begin
          p = exp_q.pop_front();
          check("id_instr", id_instruction, mem_word(p, word0));
          check("id_pc4", id_pc_plus4, p + 32'd4);
          m_valid = 1'b1; m_instr = mem_word(p, word0); m_pc4 = p + 32'd4;
          exp_q.push_back(p + 32'd4);
          delivered++;
          idle = 0;
        end
      end else begin
        m_valid = 1'b0;
      end
      if (idle > 200) begin
        checks++; errors++;
        $display("FAIL liveness: no delivery or redirect for %0d cycles", idle);
        idle = 0;
      end
    end
  end

  task automatic wait_accept(input string name, output logic [31:0] a, output bit ok);
    int n = 0;
    while (acc_q.size() == 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = (acc_q.size() != 0);
    a  = ok ? acc_q.pop_front() : 32'h0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s: no request accepted within 100 cycles got none expected one", name);
    end
  endtask

  task automatic get_accept(input string name, input logic [31:0] exp);
    logic [31:0] a;
    bit ok;
    wait_accept(name, a, ok);
    if (ok) check(name, a, exp);
  endtask

  initial begin : main
    logic [31:0] a, saved;
    bit ok, found;
    int n;
    reset = 1'b0; pc_src = PCSRC_SEQ; branch_target = '0; jr_target = '0;
    id_stall = 1'b0; ready = 1'b1; lat = 1; word0 = 32'h2008_0005;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_req", 32'(bus.imem_req), 32'h0);
    check("rst_valid", 32'(id_valid), 32'h0);
    check("rst_instr", id_instruction, 32'h0);
    check("rst_pc4", id_pc_plus4, 32'h0);

    // Sequential fetch with 1-cycle memory
    acc_q.delete();
    reset = 1'b1; mon_en = 1'b1;
    repeat (2) @(negedge clk);
    check("first_valid", 32'(id_valid), 32'h1);
    check("first_instr", id_instruction, 32'h2008_0005);
    check("first_pc4", id_pc_plus4, 32'h4);
    get_accept("seq_addr0", 32'h0);
    get_accept("seq_addr1", 32'h4);
    get_accept("seq_addr2", 32'h8);

    // Stall across a response: hold buffer, release next cycle
    saved = id_instruction;
    id_stall = 1'b1;
    repeat (3) @(negedge clk);
    check("stall_instr_kept", id_instruction, saved);
    id_stall = 1'b0;
    @(negedge clk);
    check("stall_release_valid", 32'(id_valid), 32'h1);

    // j 0x0800_0010 sitting in ID with pc+4 = 4
    reset = 1'b0; word0 = 32'h0800_0010; acc_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    pc_src = PCSRC_J;
    @(negedge clk);
    pc_src = PCSRC_SEQ;
    check("j_bubble", 32'(id_valid), 32'h0);
    get_accept("j_addr0", 32'h0);
    get_accept("j_addr_killed", 32'h4);
    get_accept("j_target", 32'h40);

    // Branch while a slow fetch is outstanding and ID is stalled
    lat = 3; acc_q.delete();
    wait_accept("br_setup", a, ok);
    id_stall = 1'b1; pc_src = PCSRC_BR; branch_target = 32'h100;
    @(negedge clk);
    pc_src = PCSRC_SEQ;
    check("br_flush_valid", 32'(id_valid), 32'h0);
    acc_q.delete();
    repeat (4) @(negedge clk);
    id_stall = 1'b0;
    get_accept("br_target", 32'h100);

    // jr held off by stall, then taken
    lat = 1;
    n = 0;
    while (!id_valid && n < 50) begin @(negedge clk); n++; end
    check("jr_setup_valid", 32'(id_valid), 32'h1);
    id_stall = 1'b1; pc_src = PCSRC_JR; jr_target = 32'h3C; acc_q.delete();
    repeat (3) @(negedge clk);
    found = 1'b0;
    foreach (acc_q[i]) if (acc_q[i] == 32'h3C) found = 1'b1;
    check("jr_ignored_in_stall", 32'(found), 32'h0);
    check("jr_stall_valid", 32'(id_valid), 32'h1);
    id_stall = 1'b0;
    @(negedge clk);
    pc_src = PCSRC_SEQ;
    check("jr_bubble", 32'(id_valid), 32'h0);
    acc_q.delete();
    get_accept("jr_target", 32'h3C);

    // Asynchronous reset while waiting on memory
    lat = 3; acc_q.delete();
    wait_accept("rst_setup", a, ok);
    #2 reset = 1'b0;
    #1;
    check("async_req", 32'(bus.imem_req), 32'h0);
    check("async_valid", 32'(id_valid), 32'h0);
    check("async_instr", id_instruction, 32'h0);
    check("async_pc4", id_pc_plus4, 32'h0);
    @(negedge clk);
    lat = 1; word0 = 32'h2008_0005; acc_q.delete();
    reset = 1'b1;
    get_accept("post_reset_addr", 32'h0);

    // Randomized controller and memory
    lat = 0;
    for (int i = 0; i < 3000; i++) begin
      int r;
      @(negedge clk);
      id_stall = ($urandom_range(99, 0) < 25);
      ready    = ($urandom_range(99, 0) < 70);
      r = int'($urandom_range(99, 0));
      pc_src = (r < 80) ? PCSRC_SEQ : (r < 87) ? PCSRC_BR : (r < 94) ? PCSRC_J : PCSRC_JR;
      branch_target = ($urandom_range(99, 0) < 5) ? 32'hFFFF_FFFC : $urandom;
      jr_target     = $urandom;
    end
    id_stall = 1'b0; pc_src = PCSRC_SEQ; ready = 1'b1;
    repeat (20) @(negedge clk);
    check("deliveries_seen", 32'(delivered > 100), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
